// File: rtl/reg_aq_shift_pkg.sv
// Shared constants for the A:Q:Q-1 working register: control-bit indices,
// shift-mode encoding and the counter-width helper.
package reg_aq_shift_pkg;

  localparam int W_DEFAULT = 64;

  localparam int CTRL_N  = 5;
  localparam int C_LD_Q  = 0;
  localparam int C_LD_A  = 1;
  localparam int C_CLR_A = 2;
  localparam int C_ASR   = 3;
  localparam int C_SHL   = 4;

  typedef enum logic {
    MODE_ASR = 1'b0,
    MODE_SHL = 1'b1
  } shift_mode_e;

  // Enough bits to count from 0 up to and including w shifts.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/reg_aq_shift_if.sv
// Control/data bundle between the multiply/divide control unit and reg_aq_shift.
// Optional outbus/out_sel ports appear when REG_AQ_OUTBUS_EN is defined.
interface reg_aq_shift_if
  import reg_aq_shift_pkg::*;
#(
  parameter int W = W_DEFAULT
);
  localparam int CNT_W = cnt_width(W);

  logic             c_ld_q;
  logic             c_ld_a;
  logic             c_clr_a;
  logic             c_asr;
  logic             c_shl;
  logic             qbit_in;
  logic [W-1:0]     inbus;
  logic [W-1:0]     alu_in;
  logic [W-1:0]     a_q;
  logic [W-1:0]     q_q;
  logic             qm1;
  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             err;
`ifdef REG_AQ_OUTBUS_EN
  logic             out_sel;
  logic [W-1:0]     outbus;
`endif

  modport master (
    output c_ld_q, c_ld_a, c_clr_a, c_asr, c_shl, qbit_in, inbus, alu_in,
`ifdef REG_AQ_OUTBUS_EN
    output out_sel,
    input  outbus,
`endif
    input  a_q, q_q, qm1, cnt, done, err
  );

  modport slave (
    input  c_ld_q, c_ld_a, c_clr_a, c_asr, c_shl, qbit_in, inbus, alu_in,
`ifdef REG_AQ_OUTBUS_EN
    input  out_sel,
    output outbus,
`endif
    output a_q, q_q, qm1, cnt, done, err
  );

endinterface

// File: rtl/reg_aq_shift_core.sv
// Combinational next value of {A,Q,Q-1} for one Booth ASR or division SHL step,
// with the A source S already selected (A or the adder result).
module reg_aq_shift_core
  import reg_aq_shift_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] q_i,
  input  logic         qm1_i,
  input  shift_mode_e  mode_i,
  input  logic         qbit_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] q_o,
  output logic         qm1_o
);

  always_comb begin
    a_o   = s_i;
    q_o   = q_i;
    qm1_o = qm1_i;
    case (mode_i)
      MODE_ASR: begin
        a_o   = {s_i[W-1], s_i[W-1:1]};
        q_o   = {s_i[0], q_i[W-1:1]};
        qm1_o = q_i[0];
      end
      MODE_SHL: begin
        a_o   = {s_i[W-2:0], q_i[W-1]};
        q_o   = {q_i[W-2:0], qbit_i};
        qm1_o = qm1_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_aq_shift.sv
// A:Q:Q-1 working register with load/clear, fused load-and-shift, shift counter
// and done/err flags. Optional registered outbus under REG_AQ_OUTBUS_EN.
module reg_aq_shift
  import reg_aq_shift_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input logic           clk,
  input logic           rst_b,
  reg_aq_shift_if.slave bus
);
  localparam int CNT_W = cnt_width(W);

  logic [CTRL_N-1:0] ctrl;
  logic [W-1:0]      a_q, a_d, q_q, q_d;
  logic              qm1_q, qm1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              done_q, done_d, err_q, err_d;
  logic              illegal, shift_ok;
  logic [W-1:0]      s_val, core_a, core_q;
  logic              core_qm1;
  shift_mode_e       mode;

  assign ctrl[C_LD_Q]  = bus.c_ld_q;
  assign ctrl[C_LD_A]  = bus.c_ld_a;
  assign ctrl[C_CLR_A] = bus.c_clr_a;
  assign ctrl[C_ASR]   = bus.c_asr;
  assign ctrl[C_SHL]   = bus.c_shl;

  assign illegal = (ctrl[C_ASR] & ctrl[C_SHL]) |
                   (ctrl[C_LD_Q] & (ctrl[C_ASR] | ctrl[C_SHL]));
  // A clear in the same cycle, an illegal combination or a finished count all veto the shift.
  assign shift_ok = (ctrl[C_ASR] | ctrl[C_SHL]) & ~illegal & ~ctrl[C_CLR_A] & ~done_q;
  assign s_val    = ctrl[C_LD_A] ? bus.alu_in : a_q;
  assign mode     = ctrl[C_SHL] ? MODE_SHL : MODE_ASR;
  assign cnt_inc  = cnt_q + 1'b1;

  reg_aq_shift_core #(.W(W)) u_core (
    .s_i    (s_val),
    .q_i    (q_q),
    .qm1_i  (qm1_q),
    .mode_i (mode),
    .qbit_i (bus.qbit_in),
    .a_o    (core_a),
    .q_o    (core_q),
    .qm1_o  (core_qm1)
  );

  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    qm1_d  = qm1_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    err_d  = err_q;
    if (shift_ok) begin
      a_d    = core_a;
      q_d    = core_q;
      qm1_d  = core_qm1;
      cnt_d  = cnt_inc;
      done_d = (cnt_inc == CNT_W'(W));
    end else begin
      if (ctrl[C_CLR_A])     a_d = '0;
      else if (ctrl[C_LD_A]) a_d = bus.alu_in;
      if (ctrl[C_LD_Q]) begin
        q_d   = bus.inbus;
        qm1_d = 1'b0;
      end
    end
    if (ctrl[C_CLR_A]) begin
      cnt_d  = '0;
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    // Flagging an illegal command outranks a simultaneous clear of the flag.
    if (illegal) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      a_q    <= '0;
      q_q    <= '0;
      qm1_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      qm1_q  <= qm1_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign bus.a_q  = a_q;
  assign bus.q_q  = q_q;
  assign bus.qm1  = qm1_q;
  assign bus.cnt  = cnt_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

`ifdef REG_AQ_OUTBUS_EN
  logic [W-1:0] outbus_q;

  always_ff @(posedge clk) begin
    if (!rst_b) outbus_q <= '0;
    else        outbus_q <= bus.out_sel ? q_q : a_q;
  end

  assign bus.outbus = outbus_q;
`endif

endmodule

// File: tb/tb_reg_aq_shift.sv
// Randomised and directed bench for reg_aq_shift (W=8) against an arithmetic model of
// the A:Q:Q-1 register; also exercises outbus when REG_AQ_OUTBUS_EN is defined.
module tb_reg_aq_shift;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_b;
  logic out_sel;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   started = 0;

  reg_aq_shift_if #(.W(W)) bus ();

  reg_aq_shift #(.W(W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

`ifdef REG_AQ_OUTBUS_EN
  assign bus.out_sel = out_sel;
`endif

  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the concatenated register.
  logic [W-1:0] m_a, m_q, m_out;
  logic         m_qm1, m_done, m_err;
  int           m_cnt;

  always @(posedge clk) begin
    logic               ill, shifting;
    logic [W-1:0]       s;
    logic signed [2*W:0] big;
    logic [2*W-1:0]     b2;
    if (!rst_b) begin
      m_a = '0; m_q = '0; m_qm1 = 0; m_cnt = 0; m_done = 0; m_err = 0; m_out = '0;
      started = 1;
    end else begin
      m_out = out_sel ? m_q : m_a;
      ill = (bus.c_asr && bus.c_shl) || (bus.c_ld_q && (bus.c_asr || bus.c_shl));
      s = bus.c_ld_a ? bus.alu_in : m_a;
      shifting = (bus.c_asr || bus.c_shl) && !ill && !bus.c_clr_a && (m_cnt != W);
      if (shifting && bus.c_asr) begin
        big = $signed({s, m_q, m_qm1}) >>> 1;
        {m_a, m_q, m_qm1} = big;
        m_cnt++;
      end else if (shifting) begin
        b2 = ({s, m_q} << 1) | (2*W)'(bus.qbit_in);
        {m_a, m_q} = b2;
        m_cnt++;
      end else begin
        if (bus.c_clr_a) m_a = '0;
        else if (bus.c_ld_a) m_a = bus.alu_in;
        if (bus.c_ld_q) begin m_q = bus.inbus; m_qm1 = 0; end
      end
      if (bus.c_clr_a) begin m_cnt = 0; m_err = 0; end
      if (ill) m_err = 1;
      m_done = (m_cnt == W);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("a_q",  64'(bus.a_q), 64'(m_a));
      check("q_q",  64'(bus.q_q), 64'(m_q));
      check("qm1",  64'(bus.qm1), 64'(m_qm1));
      check("cnt",  64'(bus.cnt), 64'(m_cnt));
      check("done", 64'(bus.done), 64'(m_done));
      check("err",  64'(bus.err), 64'(m_err));
`ifdef REG_AQ_OUTBUS_EN
      check("outbus", 64'(bus.outbus), 64'(m_out));
`endif
    end
  end

  // Drive one cycle of controls, then return just after the following negedge.
  task automatic apply(input logic ldq, lda, clr, asr, shl, qb,
                       input logic [W-1:0] inb, alu, input logic sel);
    bus.c_ld_q = ldq; bus.c_ld_a = lda; bus.c_clr_a = clr;
    bus.c_asr = asr; bus.c_shl = shl; bus.qbit_in = qb;
    bus.inbus = inb; bus.alu_in = alu; out_sel = sel;
    @(negedge clk); #1;
    $display("vec ldq=%b lda=%b clr=%b asr=%b shl=%b qb=%b in=%h alu=%h -> A=%h Q=%h qm1=%b cnt=%0d done=%b err=%b",
             ldq, lda, clr, asr, shl, qb, inb, alu, bus.a_q, bus.q_q, bus.qm1, bus.cnt, bus.done, bus.err);
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic clr();
    apply(0, 0, 1, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic asr();
    apply(0, 0, 0, 1, 0, 0, '0, '0, 0);
  endtask

  initial begin
    logic [W-1:0] ha, hq;
    rst_b = 0;
    out_sel = 0;
    bus.c_ld_q = 0; bus.c_ld_a = 0; bus.c_clr_a = 0; bus.c_asr = 0; bus.c_shl = 0;
    bus.qbit_in = 0; bus.inbus = '0; bus.alu_in = '0;
    @(negedge clk); #1;
    idle();
    check("rst_a", 64'(bus.a_q), 64'h0);
    check("rst_cnt", 64'(bus.cnt), 64'h0);
    check("rst_err", 64'(bus.err), 64'h0);
    rst_b = 1;

    // 1: load, clear, one Booth shift
    apply(1, 0, 0, 0, 0, 0, 8'hA5, '0, 0);
    clr();
    asr();
    check("t1_a", 64'(bus.a_q), 64'h00);
    check("t1_q", 64'(bus.q_q), 64'h52);
    check("t1_qm1", 64'(bus.qm1), 64'h1);
    check("t1_cnt", 64'(bus.cnt), 64'h1);

    // 2: fused add-and-shift
    clr();
    apply(1, 0, 0, 0, 0, 0, 8'h03, '0, 0);
    apply(0, 1, 0, 1, 0, 0, '0, 8'hF8, 0);
    check("t2_a", 64'(bus.a_q), 64'hFC);
    check("t2_q", 64'(bus.q_q), 64'h01);
    check("t2_qm1", 64'(bus.qm1), 64'h1);

    // 3: division shift left with quotient bit
    clr();
    apply(1, 0, 0, 0, 0, 0, 8'h40, '0, 0);
    apply(0, 1, 0, 0, 0, 0, '0, 8'h81, 0);
    apply(0, 0, 0, 0, 1, 1, '0, '0, 0);
    check("t3_a", 64'(bus.a_q), 64'h02);
    check("t3_q", 64'(bus.q_q), 64'h81);
    check("t3_qm1", 64'(bus.qm1), 64'h0);

    // 4: count to W, then further shifts are ignored
    clr();
    apply(1, 0, 0, 0, 0, 0, 8'h96, '0, 0);
    for (int i = 0; i < W; i++) asr();
    check("t4_cnt", 64'(bus.cnt), 64'h8);
    check("t4_done", 64'(bus.done), 64'h1);
    ha = m_a; hq = m_q;
    asr();
    check("t4_hold_a", 64'(bus.a_q), 64'(ha));
    check("t4_hold_q", 64'(bus.q_q), 64'(hq));
    check("t4_hold_cnt", 64'(bus.cnt), 64'h8);
    check("t4_err", 64'(bus.err), 64'h0);

    // 5: illegal asr+shl
    clr();
    apply(1, 0, 0, 0, 0, 0, 8'h5A, '0, 0);
    apply(0, 0, 0, 1, 1, 0, '0, '0, 0);
    check("t5_err", 64'(bus.err), 64'h1);
    check("t5_q", 64'(bus.q_q), 64'h5A);
    check("t5_cnt", 64'(bus.cnt), 64'h0);
    clr();
    check("t5_clr_err", 64'(bus.err), 64'h0);
    check("t5_clr_cnt", 64'(bus.cnt), 64'h0);

    // 6: mid-operation reset
    clr();
    apply(1, 0, 0, 0, 0, 0, 8'hC7, '0, 0);
    for (int i = 0; i < 5; i++) asr();
    rst_b = 0; #1;
    check("t6_pre_cnt", 64'(bus.cnt), 64'h5);
    idle();
    check("t6_cnt", 64'(bus.cnt), 64'h0);
    check("t6_q", 64'(bus.q_q), 64'h0);
    check("t6_qm1", 64'(bus.qm1), 64'h0);
    rst_b = 1;
`ifdef REG_AQ_OUTBUS_EN
    apply(1, 1, 0, 0, 0, 0, 8'h3C, 8'hC3, 0);
    apply(0, 0, 0, 0, 0, 0, '0, '0, 1);
    check("t6_outbus_q", 64'(bus.outbus), 64'h3C);
    apply(0, 0, 0, 0, 0, 0, '0, '0, 0);
    check("t6_outbus_a", 64'(bus.outbus), 64'hC3);
`endif

    // Randomised traffic, occasional clears and resets
    for (int i = 0; i < 400; i++) begin
      logic ldq, lda, cl, sa, sl;
      rst_b = ($urandom_range(0, 59) != 0);
      ldq = ($urandom_range(0, 5) == 0);
      lda = ($urandom_range(0, 2) == 0);
      cl  = ($urandom_range(0, 11) == 0);
      sa  = ($urandom_range(0, 2) == 0);
      sl  = ($urandom_range(0, 3) == 0);
      apply(ldq, lda, cl, sa, sl, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    rst_b = 1;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
